// File: rtl/wb_unit_if.sv
// Bundle of the writeback unit's upstream handshake, memory-controller read
// return and register-file write ports. Signal names match the unit's pin list.
interface wb_unit_if #(
    parameter int REG_AW = 4
) ();
    logic              i_wb_vld;
    logic              o_wb_rdy;
    logic [31:0]       i_wb_op;
    logic              i_wb_rd_src;
    logic              i_wb_rd_vld;
    logic [REG_AW-1:0] i_wb_rd_code;
    logic [1:0]        i_wb_ld_size;
    logic              i_wb_ld_signed;
    logic [1:0]        i_wb_addr_lo;
    logic              i_wb_rn_vld;
    logic [REG_AW-1:0] i_wb_rn_code;
    logic [31:0]       i_wb_rn_val;
    logic              i_memctrl_rvld;
    logic [31:0]       i_memctrl_rdata;
    logic              o_rd_en_wb;
    logic [REG_AW-1:0] o_rd_code_wb;
    logic [31:0]       o_rd_reg_wb;
    logic              o_rn_en_wb;
    logic [REG_AW-1:0] o_rn_code_wb;
    logic [31:0]       o_rn_reg_wb;
    logic              o_ld_timeout;

    modport master (
        output i_wb_vld, i_wb_op, i_wb_rd_src, i_wb_rd_vld, i_wb_rd_code,
               i_wb_ld_size, i_wb_ld_signed, i_wb_addr_lo, i_wb_rn_vld,
               i_wb_rn_code, i_wb_rn_val, i_memctrl_rvld, i_memctrl_rdata,
        input  o_wb_rdy, o_rd_en_wb, o_rd_code_wb, o_rd_reg_wb, o_rn_en_wb,
               o_rn_code_wb, o_rn_reg_wb, o_ld_timeout
    );

    modport slave (
        input  i_wb_vld, i_wb_op, i_wb_rd_src, i_wb_rd_vld, i_wb_rd_code,
               i_wb_ld_size, i_wb_ld_signed, i_wb_addr_lo, i_wb_rn_vld,
               i_wb_rn_code, i_wb_rn_val, i_memctrl_rvld, i_memctrl_rdata,
        output o_wb_rdy, o_rd_en_wb, o_rd_code_wb, o_rd_reg_wb, o_rn_en_wb,
               o_rn_code_wb, o_rn_reg_wb, o_ld_timeout
    );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: holds one retiring instruction, waits (with timeout) for load
// data, aligns/extends it and drives the Rd and optional Rn register-file ports.
module wb_unit #(
    parameter int REG_AW           = 4,
    parameter int MEM_TIMEOUT      = 15,
    parameter int ROTATE_UNALIGNED = 1,
    parameter int RN_PORT_EN       = 1
) (
    input  logic    i_clk,
    input  logic    i_rst,
    wb_unit_if.slave bus
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RETIRE,
        ST_ABORT
    } state_e;

    typedef struct packed {
        logic [31:0]       op;
        logic              rd_src;
        logic              rd_vld;
        logic [REG_AW-1:0] rd_code;
        logic [1:0]        ld_size;
        logic              ld_signed;
        logic [1:0]        addr_lo;
        logic              rn_vld;
        logic [REG_AW-1:0] rn_code;
        logic [31:0]       rn_val;
    } instr_t;

    state_e            state_q, state_d;
    instr_t            instr_q, instr_d;
    instr_t            in_instr, cur;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic              rd_en_q, rd_en_d;
    logic [REG_AW-1:0] rd_code_q, rd_code_d;
    logic [31:0]       rd_reg_q, rd_reg_d;
    logic              rn_en_q, rn_en_d;
    logic [REG_AW-1:0] rn_code_q, rn_code_d;
    logic [31:0]       rn_reg_q, rn_reg_d;
    logic              timeout_q, timeout_d;
    logic              wb_rdy, accept, rd_wr, rn_wr;
    logic [31:0]       ld_data;
    logic [63:0]       rdata_dbl;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign wb_rdy  = (state_q == ST_IDLE);
    assign accept  = bus.i_wb_vld && wb_rdy;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        in_instr.op        = bus.i_wb_op;
        in_instr.rd_src    = bus.i_wb_rd_src;
        in_instr.rd_vld    = bus.i_wb_rd_vld;
        in_instr.rd_code   = bus.i_wb_rd_code;
        in_instr.ld_size   = bus.i_wb_ld_size;
        in_instr.ld_signed = bus.i_wb_ld_signed;
        in_instr.addr_lo   = bus.i_wb_addr_lo;
        in_instr.rn_vld    = bus.i_wb_rn_vld;
        in_instr.rn_code   = bus.i_wb_rn_code;
        in_instr.rn_val    = bus.i_wb_rn_val;
    end

    // Instruction retiring straight out of IDLE has not been latched yet.
    assign cur = (state_q == ST_IDLE) ? in_instr : instr_q;

    always_comb begin
        rdata_dbl = {bus.i_memctrl_rdata, bus.i_memctrl_rdata};
        ld_byte   = 8'(bus.i_memctrl_rdata >> {instr_q.addr_lo, 3'b000});
        ld_half   = 16'(bus.i_memctrl_rdata >> {instr_q.addr_lo[1], 4'b0000});
        case (instr_q.ld_size)
            2'b00:   ld_data = {{24{instr_q.ld_signed & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{instr_q.ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = (ROTATE_UNALIGNED != 0)
                             ? 32'(rdata_dbl >> {instr_q.addr_lo, 3'b000})
                             : bus.i_memctrl_rdata;
        endcase
    end

    // NOTE: every comb output gets a default before the case so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d = in_instr;
                    cnt_d   = '0;
                    state_d = (in_instr.rd_src && in_instr.rd_vld) ? ST_WAIT : ST_RETIRE;
                end
            end
            ST_WAIT: begin
                if (bus.i_memctrl_rvld) begin
                    state_d = ST_RETIRE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_LIM) state_d = ST_ABORT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered: computed on the transition into RETIRE/ABORT.
    always_comb begin
        rd_en_d   = 1'b0;
        rn_en_d   = 1'b0;
        rd_code_d = rd_code_q;
        rd_reg_d  = rd_reg_q;
        rn_code_d = rn_code_q;
        rn_reg_d  = rn_reg_q;
        timeout_d = (state_d == ST_ABORT);
        rd_wr     = (state_d == ST_RETIRE) && cur.rd_vld;
        rn_wr     = ((state_d == ST_RETIRE) || (state_d == ST_ABORT)) && (RN_PORT_EN != 0)
                    && cur.rn_vld && !(rd_wr && (cur.rd_code == cur.rn_code));
        if (rd_wr) begin
            rd_en_d   = 1'b1;
            rd_code_d = cur.rd_code;
            rd_reg_d  = cur.rd_src ? ld_data : cur.op;
        end
        if (rn_wr) begin
            rn_en_d   = 1'b1;
            rn_code_d = cur.rn_code;
            rn_reg_d  = cur.rn_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_code_q <= '0;
            rd_reg_q  <= '0;
            rn_en_q   <= 1'b0;
            rn_code_q <= '0;
            rn_reg_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            rd_en_q   <= rd_en_d;
            rd_code_q <= rd_code_d;
            rd_reg_q  <= rd_reg_d;
            rn_en_q   <= rn_en_d;
            rn_code_q <= rn_code_d;
            rn_reg_q  <= rn_reg_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_wb_rdy     = wb_rdy;
    assign bus.o_rd_en_wb   = rd_en_q;
    assign bus.o_rd_code_wb = rd_code_q;
    assign bus.o_rd_reg_wb  = rd_reg_q;
    assign bus.o_rn_en_wb   = rn_en_q;
    assign bus.o_rn_code_wb = rn_code_q;
    assign bus.o_rn_reg_wb  = rn_reg_q;
    assign bus.o_ld_timeout = timeout_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: default instance plus one with no rotation,
// no base port and a short timeout.
module tb_wb_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    wb_unit_if #(.REG_AW(4)) a ();
    wb_unit_if #(.REG_AW(4)) b ();

    wb_unit #(.REG_AW(4), .MEM_TIMEOUT(15), .ROTATE_UNALIGNED(1), .RN_PORT_EN(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .bus(a)
    );
    wb_unit #(.REG_AW(4), .MEM_TIMEOUT(4), .ROTATE_UNALIGNED(0), .RN_PORT_EN(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .bus(b)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for a single accept edge, then drops valid.
    task automatic send_a(input logic [31:0] op, input logic rd_src, input logic rd_vld,
                          input logic [3:0] rd_code, input logic [1:0] size, input logic sgn,
                          input logic [1:0] addr, input logic rn_vld, input logic [3:0] rn_code,
                          input logic [31:0] rn_val);
        a.i_wb_vld = 1'b1; a.i_wb_op = op; a.i_wb_rd_src = rd_src; a.i_wb_rd_vld = rd_vld;
        a.i_wb_rd_code = rd_code; a.i_wb_ld_size = size; a.i_wb_ld_signed = sgn;
        a.i_wb_addr_lo = addr; a.i_wb_rn_vld = rn_vld; a.i_wb_rn_code = rn_code;
        a.i_wb_rn_val = rn_val;
        tick();
        a.i_wb_vld = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] op, input logic rd_src, input logic rd_vld,
                          input logic [3:0] rd_code, input logic [1:0] size, input logic sgn,
                          input logic [1:0] addr, input logic rn_vld, input logic [3:0] rn_code,
                          input logic [31:0] rn_val);
        b.i_wb_vld = 1'b1; b.i_wb_op = op; b.i_wb_rd_src = rd_src; b.i_wb_rd_vld = rd_vld;
        b.i_wb_rd_code = rd_code; b.i_wb_ld_size = size; b.i_wb_ld_signed = sgn;
        b.i_wb_addr_lo = addr; b.i_wb_rn_vld = rn_vld; b.i_wb_rn_code = rn_code;
        b.i_wb_rn_val = rn_val;
        tick();
        b.i_wb_vld = 1'b0;
    endtask

    task automatic mem_a(input logic rvld, input logic [31:0] data);
        a.i_memctrl_rvld = rvld; a.i_memctrl_rdata = data;
    endtask

    task automatic mem_b(input logic rvld, input logic [31:0] data);
        b.i_memctrl_rvld = rvld; b.i_memctrl_rdata = data;
    endtask

    initial begin
        a.i_wb_vld = 0; a.i_wb_op = 0; a.i_wb_rd_src = 0; a.i_wb_rd_vld = 0; a.i_wb_rd_code = 0;
        a.i_wb_ld_size = 0; a.i_wb_ld_signed = 0; a.i_wb_addr_lo = 0; a.i_wb_rn_vld = 0;
        a.i_wb_rn_code = 0; a.i_wb_rn_val = 0; a.i_memctrl_rvld = 0; a.i_memctrl_rdata = 0;
        b.i_wb_vld = 0; b.i_wb_op = 0; b.i_wb_rd_src = 0; b.i_wb_rd_vld = 0; b.i_wb_rd_code = 0;
        b.i_wb_ld_size = 0; b.i_wb_ld_signed = 0; b.i_wb_addr_lo = 0; b.i_wb_rn_vld = 0;
        b.i_wb_rn_code = 0; b.i_wb_rn_val = 0; b.i_memctrl_rvld = 0; b.i_memctrl_rdata = 0;

        // Reset state
        tick(); tick();
        check("rst_rdy", 32'(a.o_wb_rdy), 32'd1);
        check("rst_rd_en", 32'(a.o_rd_en_wb), 32'd0);
        check("rst_rd_reg", a.o_rd_reg_wb, 32'h0);
        check("rst_rn_en", 32'(a.o_rn_en_wb), 32'd0);
        check("rst_timeout", 32'(a.o_ld_timeout), 32'd0);
        rst = 1'b0;
        tick();

        // ALU retire, one cycle after accept
        send_a(32'hDEADBEEF, 1'b0, 1'b1, 4'd3, 2'd0, 1'b0, 2'd0, 1'b0, 4'd0, 32'h0);
        check("alu_rd_en", 32'(a.o_rd_en_wb), 32'd1);
        check("alu_rd_code", 32'(a.o_rd_code_wb), 32'd3);
        check("alu_rd_reg", a.o_rd_reg_wb, 32'hDEADBEEF);
        check("alu_rdy_low", 32'(a.o_wb_rdy), 32'd0);
        check("alu_rn_en", 32'(a.o_rn_en_wb), 32'd0);
        tick();
        check("alu_rd_en_drop", 32'(a.o_rd_en_wb), 32'd0);
        check("alu_rdy_back", 32'(a.o_wb_rdy), 32'd1);
        check("alu_rd_reg_hold", a.o_rd_reg_wb, 32'hDEADBEEF);

        // Rotated word load, rvld in accept cycle ignored, real rvld 3 cycles later
        mem_a(1'b1, 32'hFFFFFFFF);
        send_a(32'h0, 1'b1, 1'b1, 4'd4, 2'd2, 1'b0, 2'd1, 1'b0, 4'd0, 32'h0);
        mem_a(1'b0, 32'h0);
        check("ld_accept_rvld_ignored", 32'(a.o_rd_en_wb), 32'd0);
        tick(); tick();
        check("ld_wait_no_strobe", 32'(a.o_rd_en_wb), 32'd0);
        mem_a(1'b1, 32'h11223344);
        tick();
        mem_a(1'b0, 32'h0);
        check("ldw_rd_en", 32'(a.o_rd_en_wb), 32'd1);
        check("ldw_rd_code", 32'(a.o_rd_code_wb), 32'd4);
        check("ldw_rot_reg", a.o_rd_reg_wb, 32'h44112233);
        tick();

        // Signed byte, a=3
        send_a(32'h0, 1'b1, 1'b1, 4'd6, 2'd0, 1'b1, 2'd3, 1'b0, 4'd0, 32'h0);
        mem_a(1'b1, 32'h80FFFFFF);
        tick();
        mem_a(1'b0, 32'h0);
        check("ldb_rd_en", 32'(a.o_rd_en_wb), 32'd1);
        check("ldb_signed_reg", a.o_rd_reg_wb, 32'hFFFFFF80);
        tick();

        // Unsigned half, a=2
        send_a(32'h0, 1'b1, 1'b1, 4'd7, 2'd1, 1'b0, 2'd2, 1'b0, 4'd0, 32'h0);
        mem_a(1'b1, 32'h8001AAAA);
        tick();
        mem_a(1'b0, 32'h0);
        check("ldh_unsigned_reg", a.o_rd_reg_wb, 32'h00008001);
        tick();

        // Signed half, a=1 (a[0] ignored -> low half)
        send_a(32'h0, 1'b1, 1'b1, 4'd7, 2'd1, 1'b1, 2'd1, 1'b0, 4'd0, 32'h0);
        mem_a(1'b1, 32'h00008001);
        tick();
        mem_a(1'b0, 32'h0);
        check("ldh_signed_reg", a.o_rd_reg_wb, 32'hFFFF8001);
        tick();

        // Timeout: 15 cycles without rvld
        send_a(32'h0, 1'b1, 1'b1, 4'd8, 2'd2, 1'b0, 2'd0, 1'b1, 4'd5, 32'h100);
        repeat (14) tick();
        check("to_not_yet", 32'(a.o_ld_timeout), 32'd0);
        check("to_rn_not_yet", 32'(a.o_rn_en_wb), 32'd0);
        tick();
        check("to_pulse", 32'(a.o_ld_timeout), 32'd1);
        check("to_rd_en", 32'(a.o_rd_en_wb), 32'd0);
        check("to_rn_en", 32'(a.o_rn_en_wb), 32'd1);
        check("to_rn_code", 32'(a.o_rn_code_wb), 32'd5);
        check("to_rn_reg", a.o_rn_reg_wb, 32'h100);
        check("to_rd_reg_hold", a.o_rd_reg_wb, 32'hFFFF8001);
        tick();
        check("to_pulse_end", 32'(a.o_ld_timeout), 32'd0);
        check("to_rn_en_end", 32'(a.o_rn_en_wb), 32'd0);
        check("to_rdy_back", 32'(a.o_wb_rdy), 32'd1);

        // Port conflict rd == rn: Rd wins
        send_a(32'h0, 1'b1, 1'b1, 4'd2, 2'd2, 1'b0, 2'd0, 1'b1, 4'd2, 32'h55);
        mem_a(1'b1, 32'hCAFEF00D);
        tick();
        mem_a(1'b0, 32'h0);
        check("conf_rd_en", 32'(a.o_rd_en_wb), 32'd1);
        check("conf_rd_reg", a.o_rd_reg_wb, 32'hCAFEF00D);
        check("conf_rn_en", 32'(a.o_rn_en_wb), 32'd0);
        check("conf_rn_reg_hold", a.o_rn_reg_wb, 32'h100);
        tick();

        // Both ports written with distinct codes
        send_a(32'h0BADF00D, 1'b0, 1'b1, 4'd1, 2'd0, 1'b0, 2'd0, 1'b1, 4'd9, 32'h200);
        check("dual_rd_en", 32'(a.o_rd_en_wb), 32'd1);
        check("dual_rn_en", 32'(a.o_rn_en_wb), 32'd1);
        check("dual_rn_code", 32'(a.o_rn_code_wb), 32'd9);
        check("dual_rn_reg", a.o_rn_reg_wb, 32'h200);
        tick();

        // No Rd write requested
        send_a(32'h77, 1'b0, 1'b0, 4'd3, 2'd0, 1'b0, 2'd0, 1'b0, 4'd0, 32'h0);
        check("nord_rd_en", 32'(a.o_rd_en_wb), 32'd0);
        check("nord_rdy_low", 32'(a.o_wb_rdy), 32'd0);
        tick();

        // Reset during WAIT, then late rvld ignored
        send_a(32'h0, 1'b1, 1'b1, 4'd11, 2'd2, 1'b0, 2'd0, 1'b0, 4'd0, 32'h0);
        check("rw_in_wait", 32'(a.o_wb_rdy), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_a(1'b1, 32'hAAAAAAAA);
        check("rw_rdy", 32'(a.o_wb_rdy), 32'd1);
        check("rw_rd_en", 32'(a.o_rd_en_wb), 32'd0);
        check("rw_rd_reg_clr", a.o_rd_reg_wb, 32'h0);
        tick();
        mem_a(1'b0, 32'h0);
        check("rw_late_rvld", 32'(a.o_rd_en_wb), 32'd0);
        check("rw_still_idle", 32'(a.o_wb_rdy), 32'd1);
        send_a(32'h12345678, 1'b0, 1'b1, 4'd10, 2'd0, 1'b0, 2'd0, 1'b0, 4'd0, 32'h0);
        check("rw_alu_rd_en", 32'(a.o_rd_en_wb), 32'd1);
        check("rw_alu_rd_code", 32'(a.o_rd_code_wb), 32'd10);
        check("rw_alu_rd_reg", a.o_rd_reg_wb, 32'h12345678);
        tick();

        // Second instance: no base port, no rotation, timeout of 4
        send_b(32'h0BADF00D, 1'b0, 1'b1, 4'd1, 2'd0, 1'b0, 2'd0, 1'b1, 4'd9, 32'h200);
        check("b_rd_en", 32'(b.o_rd_en_wb), 32'd1);
        check("b_rn_disabled", 32'(b.o_rn_en_wb), 32'd0);
        tick();
        send_b(32'h0, 1'b1, 1'b1, 4'd4, 2'd2, 1'b0, 2'd1, 1'b0, 4'd0, 32'h0);
        mem_b(1'b1, 32'h11223344);
        tick();
        mem_b(1'b0, 32'h0);
        check("b_ldw_norot", b.o_rd_reg_wb, 32'h11223344);
        tick();
        send_b(32'h0, 1'b1, 1'b1, 4'd8, 2'd2, 1'b0, 2'd0, 1'b1, 4'd5, 32'h300);
        repeat (3) tick();
        check("b_to_not_yet", 32'(b.o_ld_timeout), 32'd0);
        tick();
        check("b_to_pulse", 32'(b.o_ld_timeout), 32'd1);
        check("b_to_rn_en", 32'(b.o_rn_en_wb), 32'd0);
        check("b_to_rd_en", 32'(b.o_rd_en_wb), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
